// File: rtl/tx_sched_pkg.sv
// Shared constants for the transmit frame scheduler: default widths, FSM state encoding, preamble word.
// Optional preamble insertion is enabled with the TX_PREAMBLE_EN macro.
package tx_sched_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int CW_W_DEF       = 12;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int SPB_DEF        = 8;

  localparam logic [11:0] PREAMBLE = 12'hAAA;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_PRE   = 3'd3;
  localparam logic [2:0] ST_SEND  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Bus between the scheduler and its neighbours (UART receiver, encoder, BPSK modulator).
// The master side is the surrounding datapath; the slave side is tx_frame_scheduler.
interface tx_frame_scheduler_if #(
  parameter int DATA_W = 8,
  parameter int CW_W   = 12,
  parameter int SPB    = 8
) ();
  localparam int IDX_W = $clog2(SPB);

  logic              en;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] enc_data;
  logic [CW_W-1:0]   enc_cw;
  logic              mod_en;
  logic              mod_bit;
  logic [IDX_W-1:0]  mod_idx;
  logic              busy;
  logic              fifo_full;
  logic              overflow;
  logic              frame_done;

  modport master (
    output en, rx_data, rx_valid, enc_cw,
    input  enc_data, mod_en, mod_bit, mod_idx, busy, fifo_full, overflow, frame_done
  );

  modport slave (
    input  en, rx_data, rx_valid, enc_cw,
    output enc_data, mod_en, mod_bit, mod_idx, busy, fifo_full, overflow, frame_done
  );
endinterface

// File: rtl/tx_sched_fifo.sv
// Small synchronous byte FIFO with full/empty flags and a one-cycle overflow pulse.
// A write into a full FIFO succeeds only if a pop happens on the same edge.
module tx_sched_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              overflow_r;
  logic              full_s;
  logic              empty_s;
  logic              do_wr_s;
  logic              do_rd_s;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign do_rd_s = rd_en && !empty_s;
  assign do_wr_s = wr_en && (!full_s || do_rd_s);

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointer and overflow bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      overflow_r <= wr_en && !do_wr_s;
    end
  end

  assign rd_data  = mem_r[rd_ptr_r[AW-1:0]];
  assign full     = full_s;
  assign empty    = empty_s;
  assign overflow = overflow_r;
endmodule

// File: rtl/tx_frame_scheduler.sv
// Transmit scheduler: buffers UART bytes, presents each to the encoder, then serialises the codeword
// MSB-first to the BPSK modulator. Define TX_PREAMBLE_EN to send the preamble word ahead of every codeword.
module tx_frame_scheduler
  import tx_sched_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CW_W       = CW_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int SPB        = SPB_DEF
) (
  input logic                 clk,
  input logic                 rst,
  tx_frame_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(SPB);
  localparam int BIT_W = $clog2(CW_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPB - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CW_W - 1);
`ifdef TX_PREAMBLE_EN
  localparam logic [CW_W-1:0]  PRE_WORD = CW_W'(PREAMBLE);
`endif

  logic [2:0]        state_r;
  logic [DATA_W-1:0] enc_data_r;
  logic [CW_W-2:0]   shift_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [IDX_W-1:0]  mod_idx_r;
  logic              mod_en_r;
  logic              mod_bit_r;
  logic              frame_done_r;
  logic [DATA_W-1:0] fifo_head_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              overflow_s;
  logic              pop_s;
  logic              start_s;

  tx_sched_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.rx_valid),
    .wr_data  (bus.rx_data),
    .rd_en    (pop_s),
    .rd_data  (fifo_head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .overflow (overflow_s)
  );

  assign pop_s   = (state_r == ST_LOAD);
  assign start_s = bus.en && !fifo_empty_s;

  // Frame sequencer. mod_bit_r carries the bit in flight; shift_r holds the bits still to go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      enc_data_r   <= '0;
      shift_r      <= '0;
      bit_cnt_r    <= '0;
      mod_idx_r    <= '0;
      mod_en_r     <= 1'b0;
      mod_bit_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          enc_data_r <= fifo_head_s;
          state_r    <= ST_LATCH;
        end
        ST_LATCH: begin
          mod_en_r  <= 1'b1;
          mod_idx_r <= '0;
          bit_cnt_r <= LAST_BIT;
`ifdef TX_PREAMBLE_EN
          mod_bit_r <= PRE_WORD[CW_W-1];
          shift_r   <= PRE_WORD[CW_W-2:0];
          state_r   <= ST_PRE;
`else
          mod_bit_r <= bus.enc_cw[CW_W-1];
          shift_r   <= bus.enc_cw[CW_W-2:0];
          state_r   <= ST_SEND;
`endif
        end
        ST_PRE, ST_SEND: begin
          // Power-of-two SPB lets the sample index wrap to 0 on its own.
          mod_idx_r <= mod_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          if (mod_idx_r == LAST_IDX) begin
            if (bit_cnt_r != {BIT_W{1'b0}}) begin
              mod_bit_r <= shift_r[CW_W-2];
              shift_r   <= {shift_r[CW_W-3:0], 1'b0};
              bit_cnt_r <= bit_cnt_r - {{(BIT_W-1){1'b0}}, 1'b1};
            end else if (state_r == ST_PRE) begin
              // enc_data has been stable since LOAD, so enc_cw is still valid here.
              mod_bit_r <= bus.enc_cw[CW_W-1];
              shift_r   <= bus.enc_cw[CW_W-2:0];
              bit_cnt_r <= LAST_BIT;
              state_r   <= ST_SEND;
            end else begin
              mod_en_r     <= 1'b0;
              mod_bit_r    <= 1'b0;
              frame_done_r <= 1'b1;
              state_r      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_r <= start_s ? ST_LOAD : ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          mod_en_r  <= 1'b0;
          mod_bit_r <= 1'b0;
          mod_idx_r <= '0;
        end
      endcase
    end
  end

  assign bus.enc_data   = enc_data_r;
  assign bus.mod_en     = mod_en_r;
  assign bus.mod_bit    = mod_bit_r;
  assign bus.mod_idx    = mod_idx_r;
  assign bus.busy       = (state_r != ST_IDLE);
  assign bus.fifo_full  = fifo_full_s;
  assign bus.overflow   = overflow_s;
  assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Self-checking bench for tx_frame_scheduler with a stub encoder (enc_cw = {4'b0101, enc_data}).
// Build with TX_PREAMBLE_EN defined to exercise the preamble variant.
module tb_tx_frame_scheduler;
  localparam int DATA_W = 8;
  localparam int CW_W   = 12;
  localparam int SPB    = 8;
`ifdef TX_PREAMBLE_EN
  localparam int FRAME_BITS = 2 * CW_W;
`else
  localparam int FRAME_BITS = CW_W;
`endif
  localparam int FRAME_CYC = FRAME_BITS * SPB;
  localparam logic [11:0] TB_PREAMBLE = 12'hAAA;

  typedef struct {
    logic [7:0]  data;
    logic [11:0] exp_cw;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic prev_en = 1'b0;
  logic rise = 1'b0;
  logic cur_bit = 1'b0;
  int   samp_cnt = 0;
  logic [23:0] cap = '0;
  logic [23:0] exp_q[$];

  tx_frame_scheduler_if #(.DATA_W(DATA_W), .CW_W(CW_W), .SPB(SPB)) bus ();
  assign bus.enc_cw = {4'b0101, bus.enc_data};

  tx_frame_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [23:0] frame_of(input logic [11:0] cw);
`ifdef TX_PREAMBLE_EN
    return {TB_PREAMBLE, cw};
`else
    return {12'h000, cw};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: rebuilds the serial word and checks it against the queued expectation.
  task automatic monitor();
    logic [23:0] exp;
    if (bus.mod_en) begin
      check("mod_idx", 32'(bus.mod_idx), 32'(samp_cnt % SPB));
      if (samp_cnt % SPB == 0) begin
        cur_bit = bus.mod_bit;
        cap = {cap[22:0], bus.mod_bit};
      end else begin
        check("mod_bit_hold", 32'(bus.mod_bit), 32'(cur_bit));
      end
      samp_cnt++;
    end else begin
      check("idle_bit_idx", 32'({bus.mod_bit, bus.mod_idx}), 32'd0);
    end
    if (bus.frame_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        exp = exp_q.pop_front();
        check("frame_bits", 32'(cap), 32'(exp));
        check("frame_len", 32'(samp_cnt), 32'(FRAME_CYC));
      end
      cap = '0;
      samp_cnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rise = bus.mod_en && !prev_en;
    prev_en = bus.mod_en;
    monitor();
  endtask

  initial begin
    vec_t vecs[5];
    int first_en, done_at, en_cnt, n_done, last_done;
    logic got;

    vecs[0] = '{data: 8'h00, exp_cw: 12'h500};
    vecs[1] = '{data: 8'hFF, exp_cw: 12'h5FF};
    vecs[2] = '{data: 8'h3C, exp_cw: 12'h53C};
    vecs[3] = '{data: 8'h81, exp_cw: 12'h581};
    vecs[4] = '{data: 8'h5A, exp_cw: 12'h55A};

    // 1: reset, then 50 quiet cycles
    rst = 1'b1; bus.en = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      check("reset_quiet", 32'({bus.enc_data, bus.mod_en, bus.mod_bit, bus.mod_idx, bus.busy,
                                bus.fifo_full, bus.overflow, bus.frame_done}), 32'd0);
    end

    // 2: single byte A5, latency and frame timing
    bus.en = 1'b1; bus.rx_data = 8'hA5; bus.rx_valid = 1'b1;
    exp_q.push_back(frame_of(12'h5A5));
    tick();
    bus.rx_valid = 1'b0;
    first_en = -1; done_at = -1; en_cnt = 0; n_done = 0;
    for (int c = 1; c <= FRAME_CYC + 10; c++) begin
      tick();
      if (bus.mod_en) begin
        en_cnt++;
        if (first_en < 0) first_en = c;
      end
      if (bus.frame_done) begin
        n_done++;
        done_at = c;
      end
    end
    check("a5_first_mod_en", 32'(first_en), 32'd3);
    check("a5_mod_en_cycles", 32'(en_cnt), 32'(FRAME_CYC));
    check("a5_done_cycle", 32'(done_at), 32'(FRAME_CYC + 3));
    check("a5_done_count", 32'(n_done), 32'd1);
    check("a5_idle_after", 32'(bus.busy), 32'd0);

    // table of single-byte frames
    for (int i = 0; i < 5; i++) begin
      bus.rx_data = vecs[i].data; bus.rx_valid = 1'b1;
      exp_q.push_back(frame_of(vecs[i].exp_cw));
      tick();
      bus.rx_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < FRAME_CYC + 20 && !got; c++) begin
        tick();
        if (bus.frame_done) got = 1'b1;
      end
      check("vec_done", 32'(got), 32'd1);
      tick();
      check("vec_idle", 32'(bus.busy), 32'd0);
    end

    // 3: six back-to-back writes with en low -> 4 queued, two overflows
    bus.en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.rx_data = 8'(8'h11 * (i + 1)); bus.rx_valid = 1'b1;
      if (i < 4) exp_q.push_back(frame_of({4'b0101, 8'(8'h11 * (i + 1))}));
      tick();
      check("ovf_pulse", 32'(bus.overflow), 32'(i >= 4));
      if (i == 3) check("fifo_full", 32'(bus.fifo_full), 32'd1);
    end
    bus.rx_valid = 1'b0;
    tick();
    check("ovf_clear", 32'(bus.overflow), 32'd0);
    check("held_while_en_low", 32'(bus.busy), 32'd0);
    bus.en = 1'b1;
    n_done = 0; last_done = -1;
    for (int c = 0; c < 4 * (FRAME_CYC + 3) + 20 && n_done < 4; c++) begin
      tick();
      if (rise && last_done >= 0) check("b2b_gap", 32'(cyc - last_done), 32'd3);
      if (bus.frame_done) begin
        n_done++;
        last_done = cyc;
      end
    end
    check("b2b_frames", 32'(n_done), 32'd4);
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // 4: en dropped at bit 5, frame completes, next byte waits for en
    bus.rx_data = 8'h77; bus.rx_valid = 1'b1;
    exp_q.push_back(frame_of(12'h577));
    tick();
    bus.rx_data = 8'h88;
    exp_q.push_back(frame_of(12'h588));
    tick();
    bus.rx_valid = 1'b0;
    en_cnt = 0;
    for (int c = 0; c < FRAME_CYC && en_cnt < 5 * SPB; c++) begin
      tick();
      if (bus.mod_en) en_cnt++;
    end
    check("reach_bit5", 32'(en_cnt), 32'(5 * SPB));
    bus.en = 1'b0;
    got = 1'b0;
    for (int c = 0; c < FRAME_CYC + 10 && !got; c++) begin
      tick();
      if (bus.frame_done) got = 1'b1;
    end
    check("en_low_completes", 32'(got), 32'd1);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("en_low_hold", 32'({bus.mod_en, bus.busy}), 32'd0);
    end
    bus.en = 1'b1;
    tick();
    check("resume_load", 32'({bus.busy, bus.mod_en}), 32'b10);
    tick();
    check("resume_latch", 32'(bus.mod_en), 32'd0);
    tick();
    check("resume_send", 32'(bus.mod_en), 32'd1);
    got = 1'b0;
    for (int c = 0; c < FRAME_CYC + 10 && !got; c++) begin
      tick();
      if (bus.frame_done) got = 1'b1;
    end
    check("resume_done", 32'(got), 32'd1);
    tick();
    check("queue_drained2", 32'(exp_q.size()), 32'd0);

    // 5: asynchronous reset at bit 7 with a byte still buffered
    bus.rx_data = 8'h99; bus.rx_valid = 1'b1;
    tick();
    bus.rx_data = 8'h66;
    tick();
    bus.rx_valid = 1'b0;
    en_cnt = 0;
    for (int c = 0; c < FRAME_CYC && en_cnt < 7 * SPB; c++) begin
      tick();
      if (bus.mod_en) en_cnt++;
    end
    check("reach_bit7", 32'(en_cnt), 32'(7 * SPB));
    rst = 1'b1;
    #2;
    check("async_rst_outputs", 32'({bus.enc_data, bus.mod_en, bus.mod_bit, bus.mod_idx, bus.busy,
                                     bus.fifo_full, bus.overflow, bus.frame_done}), 32'd0);
    exp_q.delete();
    cap = '0;
    samp_cnt = 0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("post_rst_empty", 32'({bus.mod_en, bus.busy, bus.fifo_full}), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
